// File: rtl/dma_bus_arbiter_if.sv
// Ownership handshake for the shared data-memory port: D-cache request/grant,
// per-channel DMA request/grant, burst control and the CPU stall counter.
interface dma_bus_arbiter_if #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned ID_W      = 1
);
   logic                 cpu_req;
   logic                 cpu_busy;
   logic                 cpu_gnt;
   logic [NUM_CH-1:0]    br;
   logic [NUM_CH-1:0]    bg;
   logic                 dma_beat;
   logic                 mode;
   logic [ID_W-1:0]      grant_id;
   logic                 stall_clr;
   logic [WORD_SIZE-1:0] stall_cycles;

   modport master (
      input  cpu_req, cpu_busy, br, dma_beat, mode, stall_clr,
      output cpu_gnt, bg, grant_id, stall_cycles
   );

   modport slave (
      output cpu_req, cpu_busy, br, dma_beat, mode, stall_clr,
      input  cpu_gnt, bg, grant_id, stall_cycles
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Round-robin owner arbiter for the shared data-memory port. The CPU is the default
// owner; DMA channels get the bus through dead HANDOFF/RETURN cycles.
module dma_bus_arbiter #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned ID_W      = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input logic               clk,
   input logic               reset_n,
   dma_bus_arbiter_if.master bus
);
   localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {S_CPU, S_HANDOFF, S_DMA, S_RETURN} state_t;

   state_t               state, state_nx;
   logic [ID_W-1:0]      grant_id, grant_id_nx;
   logic [ID_W-1:0]      last, last_nx;
   logic [ID_W-1:0]      winner;
   logic                 winner_vld;
   logic [BC_W-1:0]      beat_cnt, beat_cnt_nx;
   logic                 cpu_gnt, cpu_gnt_nx;
   logic [NUM_CH-1:0]    bg, bg_nx;
   logic [WORD_SIZE-1:0] stall_cycles, stall_nx;
   logic                 br_gid;
   logic                 burst_done;
   int unsigned          idx;

   assign br_gid = bus.br[grant_id];

   // Scan from last+1 with wrap; the descending loop leaves the nearest requester.
   always_comb begin
      winner     = last;
      winner_vld = 1'b0;
      idx        = 0;
      for (int unsigned i = NUM_CH; i != 0; i--) begin
         idx = (32'(last) + i) % NUM_CH;
         if (bus.br[idx]) begin
            winner     = ID_W'(idx);
            winner_vld = 1'b1;
         end
      end
   end

   // Cap reached already, or reached by the beat completing this cycle.
   assign burst_done = (beat_cnt >= BC_W'(MAX_BURST)) ||
                       (bus.dma_beat && (beat_cnt == BC_W'(MAX_BURST - 1)));

   always_comb begin
      state_nx    = state;
      grant_id_nx = grant_id;
      last_nx     = last;
      beat_cnt_nx = beat_cnt;
      case (state)
         S_CPU: begin
            if (winner_vld && !bus.cpu_busy) begin
               state_nx    = S_HANDOFF;
               grant_id_nx = winner;
            end
         end
         S_HANDOFF: begin
            if (br_gid) begin
               state_nx    = S_DMA;
               last_nx     = grant_id;
               beat_cnt_nx = '0;
            end else begin
               state_nx = S_RETURN;
            end
         end
         S_DMA: begin
            if (bus.dma_beat && (beat_cnt != BC_W'(MAX_BURST)))
               beat_cnt_nx = beat_cnt + BC_W'(1);
            if (!br_gid || (bus.mode && bus.dma_beat) || (bus.cpu_req && burst_done))
               state_nx = S_RETURN;
         end
         S_RETURN: state_nx = S_CPU;
         default:  state_nx = S_CPU;
      endcase
   end

   // Grant outputs are decoded from the next state so they come straight off flops.
   always_comb begin
      cpu_gnt_nx = (state_nx == S_CPU);
      bg_nx      = '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         bg_nx[c] = (state_nx == S_DMA) && (grant_id_nx == ID_W'(c));
   end

   always_comb begin
      stall_nx = stall_cycles;
      if (bus.stall_clr)
         stall_nx = '0;
      else if (bus.cpu_req && !cpu_gnt && (stall_cycles != '1))
         stall_nx = stall_cycles + WORD_SIZE'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_CPU;
         grant_id     <= '0;
         last         <= ID_W'(NUM_CH - 1);
         beat_cnt     <= '0;
         cpu_gnt      <= 1'b1;
         bg           <= '0;
         stall_cycles <= '0;
      end else begin
         state        <= state_nx;
         grant_id     <= grant_id_nx;
         last         <= last_nx;
         beat_cnt     <= beat_cnt_nx;
         cpu_gnt      <= cpu_gnt_nx;
         bg           <= bg_nx;
         stall_cycles <= stall_nx;
      end
   end

   assign bus.cpu_gnt      = cpu_gnt;
   assign bus.bg           = bg;
   assign bus.grant_id     = grant_id;
   assign bus.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: grant ordering through a scoreboard queue,
// grant/release latencies, burst cap, busy hold-off, stall counter and reset.
module tb_dma_bus_arbiter;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   int   exp_q[$];
   logic mon_en;
   logic [1:0] prev_bg;

   dma_bus_arbiter_if #(.WORD_SIZE(4), .NUM_CH(2), .ID_W(1)) bus ();

   dma_bus_arbiter #(.WORD_SIZE(4), .NUM_CH(2), .ID_W(1), .MAX_BURST(4)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag, input logic gnt);
      chk({tag, "_bg"}, 32'(bus.bg), 32'(0));
      chk({tag, "_gnt"}, 32'(bus.cpu_gnt), 32'(gnt));
   endtask

   // Steps until a grant appears (bounded), then checks it against the scoreboard.
   task automatic wait_grant(input string tag, input int exp_lat);
      int cyc;
      int exp_ch;
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while ((bus.bg == 2'b00) && (cyc < 8));
      exp_ch = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_bg"}, 32'(bus.bg), 32'(1) << exp_ch);
      chk({tag, "_id"}, 32'(bus.grant_id), 32'(exp_ch));
      chk({tag, "_gnt"}, 32'(bus.cpu_gnt), 32'(0));
   endtask

   // Grant safety invariants, sampled on the inactive edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_exclusive", 32'(bus.cpu_gnt && (bus.bg != 2'b00)), 32'(0));
         chk("mon_onehot0", 32'($onehot0(bus.bg)), 32'(1));
         if ((prev_bg != 2'b00) && (bus.bg != 2'b00))
            chk("mon_no_switch", 32'(bus.bg), 32'(prev_bg));
         prev_bg = bus.bg;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      mon_en        = 1'b0;
      prev_bg       = 2'b00;
      reset_n       = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_busy  = 1'b0;
      bus.br        = 2'b11;
      bus.dma_beat  = 1'b0;
      bus.mode      = 1'b0;
      bus.stall_clr = 1'b0;

      // Reset with both channels requesting
      step(2);
      mon_en = 1'b1;
      chk_idle("rst", 1'b1);
      chk("rst_stall", 32'(bus.stall_cycles), 32'(0));
      chk("rst_id", 32'(bus.grant_id), 32'(0));
      reset_n = 1'b1;
      exp_q.push_back(0);
      step(1);
      chk_idle("rst_handoff", 1'b0);
      wait_grant("rst_first", 1);

      // Round-robin in cycle-steal mode: 01, 10, 01, 10
      bus.mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back((k % 2 == 0) ? 1 : 0);
         bus.dma_beat = 1'b1;
         step(1);
         bus.dma_beat = 1'b0;
         chk_idle("rr_return", 1'b0);
         step(1);
         chk_idle("rr_cpu", 1'b1);
         step(1);
         chk_idle("rr_handoff", 1'b0);
         wait_grant("rr_grant", 1);
      end
      bus.br = 2'b00;
      step(1);
      chk_idle("rr_release", 1'b0);
      step(1);
      chk_idle("rr_back", 1'b1);

      // Burst cap with the CPU waiting
      bus.mode    = 1'b0;
      bus.cpu_req = 1'b1;
      bus.br      = 2'b01;
      exp_q.push_back(0);
      wait_grant("cap_grant", 2);
      bus.dma_beat = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         step(1);
         chk("cap_hold", 32'(bus.bg), 32'(1));
      end
      step(1);
      chk_idle("cap_drop", 1'b0);
      bus.dma_beat = 1'b0;
      step(1);
      chk("cap_cpu_back", 32'(bus.cpu_gnt), 32'(1));

      // No cap while the CPU is idle; then the saturated count releases at once
      bus.cpu_req  = 1'b0;
      bus.dma_beat = 1'b1;
      exp_q.push_back(0);
      wait_grant("nocap_grant", 2);
      begin
         int held;
         held = 0;
         for (int b = 0; b < 24; b++) begin
            step(1);
            if (bus.bg == 2'b01) held++;
         end
         chk("nocap_held", 32'(held), 32'(24));
      end
      bus.dma_beat = 1'b0;
      bus.cpu_req  = 1'b1;
      step(1);
      chk_idle("nocap_release", 1'b0);
      bus.br = 2'b00;
      step(1);
      chk("nocap_cpu_back", 32'(bus.cpu_gnt), 32'(1));
      bus.cpu_req = 1'b0;

      // Busy protection
      bus.cpu_busy = 1'b1;
      bus.br       = 2'b10;
      for (int c = 0; c < 5; c++) begin
         step(1);
         chk_idle("busy_hold", 1'b1);
      end
      bus.cpu_busy = 1'b0;
      exp_q.push_back(1);
      wait_grant("busy_grant", 2);
      bus.br = 2'b00;
      step(2);
      chk("busy_cpu_back", 32'(bus.cpu_gnt), 32'(1));

      // Stall counter: count, saturate at 15, clear, clear-with-stall
      bus.stall_clr = 1'b1;
      step(1);
      chk("stall_clear0", 32'(bus.stall_cycles), 32'(0));
      bus.stall_clr = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.br        = 2'b01;
      step(5);
      chk("stall_count4", 32'(bus.stall_cycles), 32'(4));
      step(15);
      chk("stall_sat", 32'(bus.stall_cycles), 32'(15));
      chk("stall_in_dma", 32'(bus.bg), 32'(1));
      bus.stall_clr = 1'b1;
      step(1);
      chk("stall_clr_prio", 32'(bus.stall_cycles), 32'(0));
      bus.stall_clr = 1'b0;
      step(1);
      chk("stall_restart", 32'(bus.stall_cycles), 32'(1));
      bus.br = 2'b00;
      step(2);
      chk("stall_cpu_back", 32'(bus.cpu_gnt), 32'(1));
      bus.cpu_req = 1'b0;

      // Request withdrawn during HANDOFF: no grant pulse
      bus.br = 2'b01;
      step(1);
      chk_idle("wd_handoff", 1'b0);
      bus.br = 2'b00;
      step(1);
      chk_idle("wd_return", 1'b0);
      step(1);
      chk_idle("wd_cpu", 1'b1);

      // Reset in the middle of a DMA grant
      bus.br = 2'b10;
      exp_q.push_back(1);
      wait_grant("mid_grant", 2);
      reset_n = 1'b0;
      step(1);
      chk_idle("mid_rst", 1'b1);
      chk("mid_rst_id", 32'(bus.grant_id), 32'(0));
      chk("mid_rst_stall", 32'(bus.stall_cycles), 32'(0));
      reset_n = 1'b1;
      bus.br  = 2'b11;
      exp_q.push_back(0);
      wait_grant("post_rst_grant", 2);
      bus.br = 2'b00;
      step(2);
      chk("end_cpu_back", 32'(bus.cpu_gnt), 32'(1));
      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Parametrised owner arbiter for the shared data-memory port (address2/data2/readM2/writeM2). It sits between the D-cache and NUM_CH DMA channels. It replaces the single-channel BR/BG handshake with a registered, glitch-free, round-robin grant. It supports burst and cycle-steal modes, bounds DMA burst length while the CPU is waiting, and counts CPU stall cycles. The CPU (D-cache) is the default owner. The D-cache and DMA mux the bus from cpu_gnt/bg.

## Interface
- WORD_SIZE, 16: width of stall counter
- NUM_CH, 2: number of DMA channels (1..8)
- ID_W, 1: width of grant_id; 2^ID_W >= NUM_CH
- MAX_BURST, 4: max beats a DMA channel may hold the bus while cpu_req is high (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  D-cache needs a memory transaction
- cpu_busy  in  1  D-cache transaction in flight; ownership must not be revoked
- cpu_gnt  out  1  D-cache owns the bus
- br  in  NUM_CH  per-channel bus request (level)
- bg  out  NUM_CH  per-channel bus grant, one-hot or zero
- dma_beat  in  1  granted channel completed one word transfer this cycle
- mode  in  1  0 = burst (hold until br drops), 1 = cycle-steal (release after each beat)
- grant_id  out  ID_W  index of current or last-granted channel
- stall_clr  in  1  clear stall_cycles
- stall_cycles  out  WORD_SIZE  saturating count of cycles with cpu_req=1 and cpu_gnt=0

## Operation
- FSM states: CPU, HANDOFF, DMA, RETURN. All outputs are registered and decoded from state (Moore).
- cpu_gnt=1 only in CPU. bg[grant_id]=1 only in DMA. HANDOFF and RETURN are dead cycles with no grant.
- CPU -> HANDOFF when |br && !cpu_busy. The winner is latched into grant_id at this transition.
- Winner selection: first channel with br set, scanning from (last+1) mod NUM_CH upward with wrap. last is the channel most recently moved into DMA; reset value NUM_CH-1, so channel 0 wins first.
- HANDOFF -> DMA if br[grant_id] is still 1. Otherwise HANDOFF -> RETURN (no grant is issued). Entering DMA sets last=grant_id and beat_cnt=0.
- DMA: beat_cnt increments on dma_beat and saturates at MAX_BURST. DMA -> RETURN when any of these holds:
  - (a) br[grant_id]=0;
  - (b) mode=1 && dma_beat;
  - (c) cpu_req && (beat_cnt >= MAX_BURST, or dma_beat && beat_cnt==MAX_BURST-1).
- If cpu_req=0, a burst-mode channel may hold the bus indefinitely.
- RETURN -> CPU unconditionally. CPU is held at least 1 cycle before the next handoff. If cpu_busy=1 on that cycle, CPU is held until cpu_busy=0.
- mode is sampled every cycle and is not latched per grant.
- Stall counter:
  - stall_clr has priority and sets the counter to 0.
  - Otherwise +1 when cpu_req && !cpu_gnt, saturating at 2^WORD_SIZE-1.

## Timing
- Reset (reset_n=0 at a posedge) values: state CPU, cpu_gnt=1, bg=0, grant_id=0, last=NUM_CH-1, beat_cnt=0, stall_cycles=0.
- Reset mid-DMA: bg drops and cpu_gnt rises on the same edge.
- Grant latency: br sampled high at edge t with CPU idle -> HANDOFF after t (cpu_gnt=0) -> bg=1 after t+1.
- Release latency: release condition true at edge t -> bg=0 after t -> cpu_gnt=1 after t+1.
- The two grant outputs are never both high, and there is no cycle in which a granted channel changes without a dead cycle in between.
- Simultaneous br on several channels: exactly one wins per handoff; the others wait.
- br falling during HANDOFF: no bg pulse; CPU regained 2 cycles after the fall was sampled.
- dma_beat is ignored outside DMA.
- cpu_busy is ignored outside CPU.

## Test plan
- **Reset.** Hold reset_n=0 for 2 cycles with br=2'b11 -> cpu_gnt=1, bg=0, stall_cycles=0. Release -> HANDOFF next cycle, then bg=2'b01, grant_id=0.
- **Round-robin.** br=2'b11 held, mode=1, one dma_beat per grant -> bg sequence 01, 10, 01, 10. Each grant is separated by RETURN, CPU, HANDOFF (3 cycles with bg=0, 1 of them with cpu_gnt=1).
- **Burst cap.** mode=0, br[0]=1 continuous, dma_beat every cycle:
  - with cpu_req=1: bg[0] drops after exactly 4 beats, and cpu_gnt=1 two cycles after the 4th beat;
  - repeat with cpu_req=0: bg[0] stays high for 20+ beats.
- **Busy protection.** cpu_busy=1 for 5 cycles while br[1] rises -> bg stays 0 and state stays CPU until cpu_busy falls. bg[1]=1 two cycles later.
- **Stall count and saturation.** WORD_SIZE=4, cpu_req=1, br[0] held in burst with cpu_req low... then force 20 non-granted cycles -> stall_cycles saturates at 15. stall_clr -> 0 next cycle. stall_clr together with a stall cycle -> 0.
- **Request withdrawal.** br[0] pulses 1 cycle -> HANDOFF, RETURN, CPU with bg never asserted. Separately, reset_n=0 during DMA -> bg=0 and cpu_gnt=1 on the next edge.
